pc_fetch_unit: RTL

Program-counter and fetch-request unit at the front of the processor pipeline. It holds the architectural PC and issues fetch addresses to instruction memory over a valid/ready handshake. It advances by STEP on each accepted fetch and reloads from branch/jump redirects (PC + immediate targets). Misaligned redirect targets raise a trap, which is held until acknowledged.

---
 rtl/pc_fetch_unit_pkg.sv | 18 +
 rtl/pc_fetch_unit_adder.sv | 14 +
 rtl/pc_fetch_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / fetch-request unit.
//   state_t              : FSM state encoding (BOOT, RUN, TRAP)
//   DEFAULT_RESET_VECTOR : PC after reset
//   DEFAULT_TRAP_VECTOR  : PC loaded when a trap is acknowledged
//   ALIGN_MASK           : low address bits that must be zero in a redirect target
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;
  localparam logic [1:0]  ALIGN_MASK           = 2'b11;

endpackage

// File: rtl/pc_fetch_unit_adder.sv
// Plain WIDTH-bit adder; the carry out is dropped so the sum wraps modulo 2^WIDTH.
//   a, b : operands
//   sum  : a + b (wrapping)
module pc_fetch_unit_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-request unit.
// Holds the PC, offers it to instruction memory over valid/ready, steps it on
// each accepted fetch, reloads it on redirects and traps on misaligned targets.
//   clk, rst                     : clock, async active-high reset
//   stall                        : suppress fetch issue
//   redirect_valid/target        : branch/jump reload
//   fetch_valid/ready, fetch_pc  : fetch handshake and address
//   pc_plus_step                 : PC + STEP link value (combinational)
//   fetch_count                  : accepted fetches, wraps
//   trap, trap_addr, trap_ack    : misaligned-redirect trap and its acknowledge
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              WIDTH        = 32,
  parameter int              STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] fetch_pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic [WIDTH-1:0] fetch_count,
  output logic             trap,
  output logic [WIDTH-1:0] trap_addr,
  input  logic             trap_ack
);

  state_t           state, state_n;
  logic [WIDTH-1:0] pc_n, count_n, trap_addr_n;
  logic             trap_n;
  logic             misaligned;

  pc_fetch_unit_adder #(.WIDTH(WIDTH)) u_adder (
    .a   (fetch_pc),
    .b   (WIDTH'(STEP)),
    .sum (pc_plus_step)
  );

  assign misaligned = |(redirect_target[1:0] & ALIGN_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_VECTOR;
      fetch_count <= '0;
      trap        <= 1'b0;
      trap_addr   <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= pc_n;
      fetch_count <= count_n;
      trap        <= trap_n;
      trap_addr   <= trap_addr_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = fetch_pc;
    count_n     = fetch_count;
    trap_n      = trap;
    trap_addr_n = trap_addr;
    fetch_valid = 1'b0;
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        // Valid drops during a redirect cycle so the stale PC is never issued.
        fetch_valid = !stall && !redirect_valid;
        if (redirect_valid) begin
          if (!misaligned) begin
            pc_n = redirect_target;
          end else begin
            state_n     = TRAP;
            trap_n      = 1'b1;
            trap_addr_n = redirect_target;
          end
        end else if (fetch_valid && fetch_ready) begin
          pc_n    = pc_plus_step;
          count_n = fetch_count + WIDTH'(1);
        end
      end
      TRAP: begin
        if (trap_ack) begin
          pc_n    = TRAP_VECTOR;
          trap_n  = 1'b0;
          state_n = BOOT;
        end
      end
      default: state_n = BOOT;
    endcase
  end

endmodule
